// File: rtl/sort_ram_responder.sv
// sort_ram_responder: RAM responder for the selection-sort datapath.
// Sorter reads complete after RD_LATENCY edges and writes are acknowledged
// one cycle after they commit. Sorter addresses at or beyond i_num_elems are
// range errors. The host port only uses idle, otherwise-unused cycles and is
// intended for preloading and dumping the array around a sort run.
module sort_ram_responder #(
  parameter int SIZE_ADDR  = 8,
  parameter int SIZE_DATA  = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_ADDR-1:0] i_num_elems,
  input  logic                 i_rd_en,
  input  logic                 i_wr_en,
  input  logic [SIZE_ADDR-1:0] i_addr,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  output logic [SIZE_DATA-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_wr_done,
  output logic                 o_busy,
  output logic                 o_err_range,
  output logic                 o_err_collision,
  input  logic                 i_host_en,
  input  logic                 i_host_we,
  input  logic [SIZE_ADDR-1:0] i_host_addr,
  input  logic [SIZE_DATA-1:0] i_host_wdata,
  output logic [SIZE_DATA-1:0] o_host_rdata,
  output logic                 o_host_rvalid
);

  localparam int DEPTH = 2 ** SIZE_ADDR;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;

  state_t               state, state_nx;
  logic [3:0]           cnt, cnt_nx;
  logic [SIZE_DATA-1:0] rd_pipe, rd_pipe_nx;
  logic                 range_q, range_nx;
  logic                 coll_q, coll_nx;
  logic [SIZE_DATA-1:0] rd_data_nx;
  logic                 rd_valid_nx, wr_done_nx, err_range_nx, err_coll_nx;

  logic [SIZE_DATA-1:0] mem [DEPTH];

  logic idle, in_range, sorter_req, host_ok, sorter_we, host_we, host_re;

  assign idle       = (state == IDLE);
  assign in_range   = (i_addr < i_num_elems);
  assign sorter_req = i_rd_en | i_wr_en;
  assign host_ok    = idle & i_host_en & ~sorter_req;
  assign sorter_we  = idle & i_wr_en & in_range;
  assign host_we    = host_ok & i_host_we;
  assign host_re    = host_ok & ~i_host_we;
  assign o_busy     = ~idle;

  // Memory array: no reset so contents survive i_rst_n; sorter and host
  // writes are mutually exclusive because the host needs an idle sorter.
  always_ff @(posedge i_clk) begin
    if (sorter_we) begin
      mem[i_addr] <= i_wr_data;
    end else if (host_we) begin
      mem[i_host_addr] <= i_host_wdata;
    end
  end

  // Host read port: one-edge read, data held between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_host_rdata  <= '0;
      o_host_rvalid <= 1'b0;
    end else begin
      o_host_rvalid <= host_re;
      if (host_re) begin
        o_host_rdata <= mem[i_host_addr];
      end
    end
  end

  // FSM state, latency counter, captured read data and registered strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rd_pipe         <= '0;
      range_q         <= 1'b0;
      coll_q          <= 1'b0;
      o_rd_data       <= '0;
      o_rd_valid      <= 1'b0;
      o_wr_done       <= 1'b0;
      o_err_range     <= 1'b0;
      o_err_collision <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      rd_pipe         <= rd_pipe_nx;
      range_q         <= range_nx;
      coll_q          <= coll_nx;
      o_rd_data       <= rd_data_nx;
      o_rd_valid      <= rd_valid_nx;
      o_wr_done       <= wr_done_nx;
      o_err_range     <= err_range_nx;
      o_err_collision <= err_coll_nx;
    end
  end

  // Next-state and completion logic. Range and rd+wr collision status are
  // captured at accept and replayed with the completion pulse; a request
  // arriving while busy raises the collision flag on the next cycle.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rd_pipe_nx   = rd_pipe;
    range_nx     = range_q;
    coll_nx      = coll_q;
    rd_data_nx   = o_rd_data;
    rd_valid_nx  = 1'b0;
    wr_done_nx   = 1'b0;
    err_range_nx = 1'b0;
    err_coll_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (i_wr_en) begin
          state_nx = WR_ACK;
          range_nx = ~in_range;
          coll_nx  = i_rd_en;
        end else if (i_rd_en) begin
          state_nx   = RD_WAIT;
          cnt_nx     = 4'(RD_LATENCY - 1);
          rd_pipe_nx = in_range ? mem[i_addr] : '0;
          range_nx   = ~in_range;
          coll_nx    = 1'b0;
        end
      end
      RD_WAIT: begin
        err_coll_nx = sorter_req;
        if (cnt == 4'd0) begin
          rd_valid_nx  = 1'b1;
          rd_data_nx   = rd_pipe;
          err_range_nx = range_q;
          state_nx     = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      WR_ACK: begin
        wr_done_nx   = 1'b1;
        err_range_nx = range_q;
        err_coll_nx  = sorter_req | coll_q;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
